// File: rtl/row_to_word_packer.sv
// row_to_word_packer
//   Packs a stream of narrow rows (COL_COUNT x 32-bit lanes) into dense
//   512-bit words (16 x 32-bit lanes). Rows are packed back-to-back, so one
//   row may straddle two words. A word is emitted as soon as 16 lanes are
//   filled. A row marked last flushes the residual lanes as a zero-padded
//   partial word with output_last set. That can take two words when the
//   last row overflows the current word.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   input_data      row; column c at bits [c*32 +: 32]
//   input_valid     row valid
//   input_last      last row of the stream
//   input_ready     row accepted on input_valid && input_ready
//   output_data     packed word; lane k at bits [k*32 +: 32]
//   output_lanes    number of valid lanes in the word, 1..16
//   output_valid    word valid
//   output_last     final word of the stream
//   output_ready    word consumed on output_valid && output_ready
module row_to_word_packer #(
  parameter int COL_COUNT = 3,
  parameter int FILL_BITS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COL_COUNT*32-1:0] input_data,
  input  logic                   input_valid,
  input  logic                   input_last,
  output logic                   input_ready,
  output logic [511:0]           output_data,
  output logic [4:0]             output_lanes,
  output logic                   output_valid,
  output logic                   output_last,
  input  logic                   output_ready
);

  typedef enum logic {S_PACK, S_FLUSH} state_t;

  state_t                r_state, w_state_nxt;
  logic [FILL_BITS-1:0]  r_fill, w_fill_nxt, w_n;
  logic [14:0][31:0]     r_acc, w_acc_nxt;
  logic [15:0][31:0]     r_odata, w_odata_nxt;
  logic [4:0]            r_olanes, w_olanes_nxt;
  logic                  r_olast, w_olast_nxt;
  logic                  r_ovalid, w_ovalid_nxt;
  // Residual lanes followed by the incoming row: at most 15 + 16 = 31 lanes.
  logic [30:0][31:0]     w_comb;
  logic                  w_free, w_accept;

  // Output register can take a new word if empty or being drained this cycle.
  assign w_free      = !r_ovalid || output_ready;
  assign input_ready = (r_state == S_PACK) && w_free;
  assign w_accept    = input_valid && input_ready;
  assign w_n         = r_fill + FILL_BITS'(COL_COUNT);

  assign output_data  = r_odata;
  assign output_lanes = r_olanes;
  assign output_valid = r_ovalid;
  assign output_last  = r_olast;

  // Accumulator lanes at or above fill are always zero, so the row can be
  // overlaid directly at offset fill and everything past n stays zero.
  always_comb begin
    w_comb = '0;
    for (int j = 0; j < 15; j++)
      w_comb[j] = r_acc[j];
    for (int c = 0; c < COL_COUNT; c++)
      w_comb[5'(int'(r_fill) + c)] = input_data[c*32 +: 32];
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fill_nxt   = r_fill;
    w_acc_nxt    = r_acc;
    w_odata_nxt  = r_odata;
    w_olanes_nxt = r_olanes;
    w_olast_nxt  = r_olast;
    w_ovalid_nxt = r_ovalid && !output_ready;
    case (r_state)
      S_PACK: begin
        if (w_accept) begin
          if ((w_n > FILL_BITS'(16)) || ((w_n == FILL_BITS'(16)) && !input_last)) begin
            // Full word; the overflow lanes become the new residual.
            w_odata_nxt  = w_comb[15:0];
            w_olanes_nxt = 5'd16;
            w_olast_nxt  = 1'b0;
            w_ovalid_nxt = 1'b1;
            for (int j = 0; j < 15; j++)
              w_acc_nxt[j] = w_comb[16+j];
            w_fill_nxt = w_n - FILL_BITS'(16);
            if (input_last)
              w_state_nxt = S_FLUSH;
          end else if (input_last) begin
            // Last row fits: emit the zero-padded partial (or exact) word.
            w_odata_nxt  = w_comb[15:0];
            w_olanes_nxt = 5'(w_n);
            w_olast_nxt  = 1'b1;
            w_ovalid_nxt = 1'b1;
            w_fill_nxt   = '0;
            w_acc_nxt    = '0;
          end else begin
            for (int j = 0; j < 15; j++)
              w_acc_nxt[j] = w_comb[j];
            w_fill_nxt = w_n;
          end
        end
      end
      S_FLUSH: begin
        if (w_free) begin
          w_odata_nxt  = {32'd0, r_acc};
          w_olanes_nxt = 5'(r_fill);
          w_olast_nxt  = 1'b1;
          w_ovalid_nxt = 1'b1;
          w_fill_nxt   = '0;
          w_acc_nxt    = '0;
          w_state_nxt  = S_PACK;
        end
      end
      default: w_state_nxt = S_PACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_PACK;
      r_fill   <= '0;
      r_acc    <= '0;
      r_odata  <= '0;
      r_olanes <= '0;
      r_olast  <= 1'b0;
      r_ovalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_fill   <= w_fill_nxt;
      r_acc    <= w_acc_nxt;
      r_odata  <= w_odata_nxt;
      r_olanes <= w_olanes_nxt;
      r_olast  <= w_olast_nxt;
      r_ovalid <= w_ovalid_nxt;
    end
  end

endmodule

// File: tb/tb_row_to_word_packer.sv
module tb_row_to_word_packer;
  localparam int C = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [C*32-1:0] in_d;
  logic            in_v, in_l, in_r;
  logic [511:0]    o_d;
  logic [4:0]      o_ln;
  logic            o_v, o_l, o_r;

  logic [511:0]    d16, od16;
  logic            v16, l16, r16, ov16, ol16;
  logic [4:0]      oln16;
  logic            or16;

  row_to_word_packer #(.COL_COUNT(C), .FILL_BITS(5)) u_dut (
    .clk(clk), .rst(rst),
    .input_data(in_d), .input_valid(in_v), .input_last(in_l), .input_ready(in_r),
    .output_data(o_d), .output_lanes(o_ln), .output_valid(o_v), .output_last(o_l),
    .output_ready(o_r)
  );

  row_to_word_packer #(.COL_COUNT(16), .FILL_BITS(5)) u_dut16 (
    .clk(clk), .rst(rst),
    .input_data(d16), .input_valid(v16), .input_last(l16), .input_ready(r16),
    .output_data(od16), .output_lanes(oln16), .output_valid(ov16), .output_last(ol16),
    .output_ready(or16)
  );

  typedef struct {
    logic [511:0] d;
    logic [4:0]   ln;
    logic         last;
  } word_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mode = 0;   // 0 random output_ready, 1 held low, 2 held high
  word_t       expq[$];
  word_t       got[$];
  logic [31:0] mq[$];      // model lane stream not yet emitted
  word_t       g16[$];
  int          g16c[$];
  logic        held = 1'b0;
  word_t       hw, mon_w, mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: lanes form one flat stream; every 16 lanes make a word, and
  // the last row releases whatever is left (<=16) as a padded final word.
  function automatic void model_row(input logic [C*32-1:0] d, input logic last);
    word_t w;
    for (int c = 0; c < C; c++) mq.push_back(d[c*32 +: 32]);
    while (mq.size() > 16 || (mq.size() == 16 && !last)) begin
      w.d = '0;
      for (int k = 0; k < 16; k++) w.d[k*32 +: 32] = mq.pop_front();
      w.ln = 5'd16; w.last = 1'b0;
      expq.push_back(w);
    end
    if (last) begin
      w.d = '0; w.ln = 5'(mq.size()); w.last = 1'b1;
      for (int k = 0; mq.size() > 0; k++) w.d[k*32 +: 32] = mq.pop_front();
      expq.push_back(w);
    end
  endfunction

  // Compare process: outputs and inputs are stable at the falling edge and
  // describe the handshakes of the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete(); expq.delete(); held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 512'(o_v), 512'(1'b1));
        chk("hold_data", o_d, hw.d);
        chk("hold_meta", 512'({o_ln, o_l}), 512'({hw.ln, hw.last}));
      end
      if (o_v && !o_r) chk("ready_blocked", 512'(in_r), 512'(1'b0));
      if (o_v && o_r) begin
        mon_w.d = o_d; mon_w.ln = o_ln; mon_w.last = o_l;
        got.push_back(mon_w);
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word got lanes %0d last %0d expected none", o_ln, o_l);
        end else begin
          mon_e = expq.pop_front();
          chk("word_data", o_d, mon_e.d);
          chk("word_lanes", 512'(o_ln), 512'(mon_e.ln));
          chk("word_last", 512'(o_l), 512'(mon_e.last));
        end
      end
      held = o_v && !o_r;
      hw.d = o_d; hw.ln = o_ln; hw.last = o_l;
      if (in_v && in_r) model_row(in_d, in_l);
    end
  end

  always @(negedge clk) begin
    if (!rst && ov16) begin
      mon_w.d = od16; mon_w.ln = oln16; mon_w.last = ol16;
      g16.push_back(mon_w);
      g16c.push_back(cyc);
    end
  end

  initial begin
    o_r = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (mode)
        0:       o_r = ($urandom_range(0, 9) < 7);
        1:       o_r = 1'b0;
        default: o_r = 1'b1;
      endcase
    end
  end

  function automatic logic [C*32-1:0] pat_row(input int r);
    logic [C*32-1:0] d;
    for (int c = 0; c < C; c++) d[c*32 +: 32] = {16'(r), 16'(c)};
    return d;
  endfunction

  task automatic send_row(input logic [C*32-1:0] d, input logic last);
    int n = 0;
    in_d = d; in_l = last; in_v = 1'b1;
    @(negedge clk);
    while (!in_r && n < 300) begin @(negedge clk); n++; end
    if (!in_r) begin
      checks++; errors++;
      $display("FAIL row_accept_timeout got ready 0 expected 1 within 300 cycles");
    end
    @(posedge clk); #1;
    in_v = 1'b0; in_l = 1'b0;
  endtask

  task automatic send_stream(input int nrows, input bit pat);
    logic [C*32-1:0] d;
    for (int r = 0; r < nrows; r++) begin
      if (pat) d = pat_row(r);
      else for (int c = 0; c < C; c++) d[c*32 +: 32] = $urandom;
      send_row(d, r == nrows - 1);
      if (!pat) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() > 0 || o_v) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d words pending expected 0", expq.size());
    end
    @(posedge clk); #1;
  endtask

  logic [511:0] rows16 [8];
  int           acc16  [8];

  initial begin
    in_d = '0; in_v = 1'b0; in_l = 1'b0;
    d16 = '0; v16 = 1'b0; l16 = 1'b0; or16 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 512'(o_v), 512'(1'b0));
    chk("rst_lanes", 512'(o_ln), 512'(5'd0));
    chk("rst_data", o_d, 512'(0));
    chk("rst_last", 512'(o_l), 512'(1'b0));
    @(posedge clk); #1; rst = 1'b0;

    // 16 patterned rows: three full words, only the third marked last.
    mode = 2; got.delete();
    send_stream(16, 1'b1);
    drain();
    chk("t1_count", 512'(got.size()), 512'(3));
    chk("t1_w1_lane15", 512'(got[0].d[15*32 +: 32]), 512'({16'd5, 16'd0}));
    chk("t1_last", 512'({got[0].last, got[1].last, got[2].last}), 512'(3'b001));
    chk("t1_lanes", 512'({got[0].ln, got[1].ln, got[2].ln}), 512'({5'd16, 5'd16, 5'd16}));

    // 5 rows: one 15-lane final word with a zero pad lane.
    mode = 0; got.delete();
    send_stream(5, 1'b1);
    drain();
    chk("t2_count", 512'(got.size()), 512'(1));
    chk("t2_meta", 512'({got[0].ln, got[0].last}), 512'({5'd15, 1'b1}));
    chk("t2_pad", 512'(got[0].d[15*32 +: 32]), 512'(0));
    chk("t2_lane14", 512'(got[0].d[14*32 +: 32]), 512'({16'd4, 16'd2}));

    // 6 rows: the last row overflows, forcing a separate flush word.
    mode = 2; got.delete();
    for (int r = 0; r < 5; r++) send_row(pat_row(r), 1'b0);
    send_row(pat_row(5), 1'b1);
    @(negedge clk);
    chk("t3_flush_ready", 512'(in_r), 512'(1'b0));
    drain();
    chk("t3_count", 512'(got.size()), 512'(2));
    chk("t3_w1_meta", 512'({got[0].ln, got[0].last}), 512'({5'd16, 1'b0}));
    chk("t3_w2_meta", 512'({got[1].ln, got[1].last}), 512'({5'd2, 1'b1}));
    chk("t3_w2_data", got[1].d, 512'({16'd5, 16'd2, 16'd5, 16'd1}));

    // Sustained backpressure in the middle of a random stream.
    mode = 0;
    fork
      send_stream(24, 1'b0);
      begin
        repeat (6) @(posedge clk);
        mode = 1;
        repeat (10) @(posedge clk);
        mode = 0;
      end
    join
    drain();

    repeat (6) begin
      mode = 0;
      send_stream($urandom_range(1, 20), 1'b0);
      drain();
    end

    // Reset with residual lanes and a word stuck in the output register.
    mode = 2;
    for (int r = 0; r < 10; r++) send_row(pat_row(r), 1'b0);
    mode = 1;
    send_row(pat_row(10), 1'b0);
    @(negedge clk);
    chk("t6_pending", 512'(o_v), 512'(1'b1));
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 512'(o_v), 512'(1'b0));
    @(posedge clk); #1;
    mode = 2; got.delete();
    send_stream(5, 1'b1);
    drain();
    chk("t6_count", 512'(got.size()), 512'(1));
    chk("t6_lane0", 512'(got[0].d[31:0]), 512'({16'd0, 16'd0}));
    chk("t6_lanes", 512'(got[0].ln), 512'(5'd15));

    // 16-lane rows: one word per cycle, one cycle after each accept.
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 16; k++) rows16[i][k*32 +: 32] = $urandom;
    g16.delete(); g16c.delete();
    for (int i = 0; i < 8; i++) begin
      d16 = rows16[i]; v16 = 1'b1; l16 = (i == 7);
      @(negedge clk);
      chk("t5_ready", 512'(r16), 512'(1'b1));
      acc16[i] = cyc;
      @(posedge clk); #1;
    end
    v16 = 1'b0; l16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_count", 512'(g16.size()), 512'(8));
    chk("t5_latency", 512'(g16c[0]), 512'(acc16[0] + 1));
    for (int i = 0; i < 8; i++) begin
      chk("t5_data", g16[i].d, rows16[i]);
      chk("t5_meta", 512'({g16[i].ln, g16[i].last}), 512'({5'd16, (i == 7)}));
      chk("t5_cycle", 512'(g16c[i]), 512'(g16c[0] + i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
